// File: rtl/neuron_backprop.sv
// Backward pass of the neuron block: streams delta*w_i and delta*act_i one beat per input index.
// Define NEURON_BP_SAT_EN for saturating narrowing with out_sat; otherwise narrowing wraps.
module neuron_backprop #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int FRAC  = 8,
  parameter logic [N*WIDTH-1:0] WEIGHTS_FLAT = '0,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] delta,
  input  logic [N-1:0][WIDTH-1:0] act,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IW-1:0]           out_idx,
  output logic [WIDTH-1:0]        err_out,
  output logic [WIDTH-1:0]        grad_out,
  output logic                    out_last,
  output logic                    out_sat
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [WIDTH-1:0]        err_q, err_d;
  logic [WIDTH-1:0]        grad_q, grad_d;
  logic                    last_q, last_d;
  logic                    sat_q, sat_d;
  logic signed [WIDTH-1:0] delta_q;
  logic [N-1:0][WIDTH-1:0] act_q;

  logic signed [WIDTH-1:0] w_arr [N];
  logic [IW-1:0]           mul_idx;
  logic signed [WIDTH-1:0] mul_delta;
  logic signed [WIDTH-1:0] mul_act;
  logic signed [PW-1:0]    prod_err;
  logic signed [PW-1:0]    prod_grad;
  logic [WIDTH:0]          nar_err;
  logic [WIDTH:0]          nar_grad;
  logic                    accept;
  logic                    fire;

  for (genvar g = 0; g < N; g++) begin : g_w
    assign w_arr[g] = WEIGHTS_FLAT[(N-g)*WIDTH-1 -: WIDTH];
  end

`ifdef NEURON_BP_SAT_EN
  localparam logic signed [PW-1:0] SMAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

  // Returns {clipped, value}: floor shift by FRAC, then clip or wrap to WIDTH bits.
  function automatic logic [WIDTH:0] narrow(input logic signed [PW-1:0] p);
`ifdef NEURON_BP_SAT_EN
    logic signed [PW-1:0] s;
    s = p >>> FRAC;
    if (s > SMAX) return {1'b1, SMAX[WIDTH-1:0]};
    if (s < SMIN) return {1'b1, SMIN[WIDTH-1:0]};
    return {1'b0, s[WIDTH-1:0]};
`else
    return {1'b0, WIDTH'(p >>> FRAC)};
`endif
  endfunction

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == RUN);
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;

  // Operand mux for the shared multiplier pair: beat 0 comes straight from the
  // inputs on accept, later beats from the captured copies at the next index.
  always_comb begin
    mul_idx   = '0;
    mul_delta = delta_q;
    mul_act   = act_q[0];
    if (state_q == IDLE) begin
      mul_delta = delta;
      mul_act   = act[0];
    end else begin
      mul_idx = last_q ? '0 : idx_q + IW'(1);
      mul_act = act_q[mul_idx];
    end
  end

  assign prod_err  = PW'(mul_delta) * PW'(w_arr[mul_idx]);
  assign prod_grad = PW'(mul_delta) * PW'(mul_act);
  assign nar_err   = narrow(prod_err);
  assign nar_grad  = narrow(prod_grad);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    grad_d  = grad_q;
    last_d  = last_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          idx_d   = '0;
          last_d  = (N == 1);
          err_d   = nar_err[WIDTH-1:0];
          grad_d  = nar_grad[WIDTH-1:0];
          sat_d   = nar_err[WIDTH] | nar_grad[WIDTH];
        end
      end
      RUN: begin
        if (fire) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            idx_d  = mul_idx;
            last_d = (mul_idx == IW'(N - 1));
            err_d  = nar_err[WIDTH-1:0];
            grad_d = nar_grad[WIDTH-1:0];
            sat_d  = nar_err[WIDTH] | nar_grad[WIDTH];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and beat registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      grad_q  <= '0;
      last_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      grad_q  <= grad_d;
      last_q  <= last_d;
      sat_q   <= sat_d;
    end
  end

  // Captured transaction operands
  always_ff @(posedge clk) begin
    if (accept) begin
      delta_q <= delta;
      act_q   <= act;
    end
  end

  assign out_idx  = idx_q;
  assign err_out  = err_q;
  assign grad_out = grad_q;
  assign out_last = last_q;
  assign out_sat  = sat_q;

endmodule

// File: tb/tb_neuron_backprop.sv
// Directed bench for neuron_backprop with weights {0x0200,0xFF00,0x7FFF,0x0000}.
module tb_neuron_backprop;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] delta;
  logic [3:0][15:0]   act;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_idx;
  logic [15:0]        err_out;
  logic [15:0]        grad_out;
  logic               out_last;
  logic               out_sat;

  int checks   = 0;
  int failures = 0;

  logic [36:0] got;
  assign got = {out_valid, out_idx, err_out, grad_out, out_last, out_sat};

  logic [15:0] err_b  [4] = '{16'h0200, 16'hFF00, 16'h7FFF, 16'h0000};
  logic [15:0] grad_b [4] = '{16'h0100, 16'h0080, 16'h0040, 16'hFFC0};

  neuron_backprop #(
    .WIDTH(16), .N(4), .FRAC(8),
    .WEIGHTS_FLAT(64'h0200_FF00_7FFF_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .delta(delta), .act(act),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .err_out(err_out), .grad_out(grad_out),
    .out_last(out_last), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic accept_basic();
    delta    = 16'h0100;
    act      = {16'hFFC0, 16'h0040, 16'h0080, 16'h0100};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    delta = '0; act = '0;
    #3;
    checks++;
    if (got !== 37'd0) begin
      failures++; $display("FAIL reset_outputs: got %h expected %h", got, 37'd0);
    end
    #14 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, got} !== {1'b1, 37'd0}) begin
      failures++; $display("FAIL reset_release: got %h expected %h", {in_ready, got}, {1'b1, 37'd0});
    end
  endtask

  task automatic test_basic();
    logic [36:0] exp;
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL basic_ready: got %b expected 1", in_ready);
    end
    accept_basic();
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, 2'(i), err_b[i], grad_b[i], (i == 3), 1'b0};
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL basic_beat%0d: got %h expected %h", i, got, exp);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        failures++; $display("FAIL basic_busy%0d: in_ready got %b expected 0", i, in_ready);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++; $display("FAIL basic_done: ready/valid got %b expected 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_saturation();
    logic [36:0] exp;
    out_ready = 1'b1;
    delta = 16'h7FFF; act = {16'h0000, 16'h0000, 16'h0000, 16'h7FFF};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef NEURON_BP_SAT_EN
    exp = {1'b1, 2'd0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1};
`else
    exp = {1'b1, 2'd0, 16'hFFFE, 16'hFF00, 1'b0, 1'b0};
`endif
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL sat_beat0: got %h expected %h", got, exp);
    end
    drain(4);
  endtask

  task automatic test_neg_rounding();
    logic [36:0] exp;
    out_ready = 1'b1;
    delta = 16'hFFFF; act = {16'h0000, 16'h0000, 16'h0000, 16'h0001};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp = {1'b1, 2'd0, 16'hFFFE, 16'hFFFF, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL neg_beat0: got %h expected %h", got, exp);
    end
    drain(4);
  endtask

  task automatic test_backpressure();
    logic [36:0] exp;
    out_ready = 1'b1;
    accept_basic();
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp = {1'b1, 2'd1, err_b[1], grad_b[1], 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL bp_stall%0d: got %h expected %h", k, got, exp);
      end
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    for (int i = 2; i < 4; i++) begin
      @(posedge clk); #1;
      exp = {1'b1, 2'(i), err_b[i], grad_b[i], (i == 3), 1'b0};
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL bp_beat%0d: got %h expected %h", i, got, exp);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_done: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_isolation();
    logic [36:0] exp;
    out_ready = 1'b1;
    accept_basic();
    delta    = 16'h0200;
    act      = {16'hFFFF, 16'h1234, 16'h5678, 16'h0100};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, 2'(i), err_b[i], grad_b[i], (i == 3), 1'b0};
      checks++;
      if ({in_ready, got} !== {1'b0, exp}) begin
        failures++; $display("FAIL iso_beat%0d: got %h expected %h", i, {in_ready, got}, {1'b0, exp});
      end
      @(posedge clk); #1;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL iso_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp = {1'b1, 2'd0, 16'h0400, 16'h0200, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL iso_second: got %h expected %h", got, exp);
    end
    drain(4);
  endtask

  task automatic test_reset_mid();
    logic [36:0] exp;
    out_ready = 1'b1;
    accept_basic();
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp = {1'b1, 2'd2, err_b[2], grad_b[2], 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL rst_pre_beat2: got %h expected %h", got, exp);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (got !== 37'd0) begin
      failures++; $display("FAIL rst_mid_outputs: got %h expected %h", got, 37'd0);
    end
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++; $display("FAIL rst_mid_ready: got %b expected 10", {in_ready, out_valid});
    end
    @(posedge clk); #1;
    accept_basic();
    exp = {1'b1, 2'd0, err_b[0], grad_b[0], 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL rst_restart: got %h expected %h", got, exp);
    end
    drain(4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_neg_rounding();
    test_backpressure();
    test_isolation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neuron_backprop.md
# neuron_backprop

Backward-pass companion to the combinational `neuron` dot-product block. It accepts one output-error term `delta` together with the N forward activations that produced it. It then streams N result beats, one per input index:
- the propagated input error `delta*w_i`, the transpose direction of the forward projection;
- the weight gradient `delta*act_i`.

It sits between the loss/next-layer error source and the previous layer's error input and weight-update logic. Weights are the same compile-time constants as the forward neuron.

## Interface
- `WIDTH`, 16: bit-width of delta, activations, weights and all outputs (signed two's complement).
- `N`, 4: number of inputs/weights; beats per transaction.
- `FRAC`, 8: fractional bits of the fixed-point format; products are shifted right by FRAC before narrowing.
- `WEIGHTS_FLAT`, all zero: packed weights. Weight i = `WEIGHTS_FLAT[(N-i)*WIDTH-1 -: WIDTH]`, so weight 0 occupies the MSBs.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  delta/act presented.
- `in_ready`  out  1  block can accept a transaction.
- `delta`  in  WIDTH  output-error term.
- `act`  in  WIDTH x [N-1:0]  forward activations, index i pairs with weight i.
- `out_valid`  out  1  result beat presented.
- `out_ready`  in  1  consumer accepts beat.
- `out_idx`  out  $clog2(N) (min 1)  input index of current beat.
- `err_out`  out  WIDTH  narrowed `delta*w[out_idx]`.
- `grad_out`  out  WIDTH  narrowed `delta*act[out_idx]`.
- `out_last`  out  1  high on beat `out_idx==N-1`.
- `out_sat`  out  1  either result of this beat was clipped.

## Operation
**FSM states:** IDLE, RUN.
- **IDLE:** `in_ready`=1, `out_valid`=0.
  - On `in_valid&&in_ready`, register `delta` and all `act`, set index=0, go to RUN.
- **RUN:** `in_ready`=0. Beat for the current index is presented with `out_valid`=1.
  - On `out_valid&&out_ready` with index<N-1: increment index.
  - On `out_valid&&out_ready` with index==N-1: go to IDLE.
  - Without `out_ready`, every output holds stable (AXI-style: valid never drops without a handshake).
- **Arithmetic:** one shared signed WIDTH x WIDTH multiplier pair producing 2*WIDTH-bit products.
  - Narrowing: arithmetic shift right by FRAC (floor toward −inf).
  - Then saturate to [−2^(WIDTH-1), 2^(WIDTH-1)−1].
- **Beat outputs:** `err_out`, `grad_out`, `out_idx`, `out_last`, `out_sat` are registered; they change only on the handshake or on IDLE→RUN.
- **Input sampling:** `act`/`delta` are captured once; changes on the inputs during RUN have no effect.
- **Reset:** asynchronous, any state → IDLE. All outputs reset to 0, except `in_ready`, which resets to 1 once `rst_n` is high. A transaction in progress is abandoned with no further beats.

## Timing
- **Latency:** input accept at edge t → first beat valid after edge t (cycle t+1).
- **Stepping:** each subsequent beat follows one cycle after the previous handshake.
- **Throughput:** minimum N+1 cycles per transaction (N beats plus one IDLE accept cycle). `in_ready` rises the cycle after the last beat's handshake.
- **Back-pressure:** `out_ready` low stalls indefinitely with no loss.
- **Edge cases:** `out_ready` constantly high gives back-to-back beats. N=1 gives a single beat with `out_last`=1.

## Configuration
- `NEURON_BP_SAT_EN` defined: saturating narrowing as above; `out_sat` reports clipping.
- `NEURON_BP_SAT_EN` undefined: wrap-around narrowing, keeping the low WIDTH bits after the shift; `out_sat` is tied 0. All timing is identical.

## Test plan
All cases use WIDTH=16, FRAC=8, N=4, weights {0x0200,0xFF00,0x7FFF,0x0000} (w0..w3).
- **Basic:** `delta`=0x0100, `act`={0x0100,0x0080,0x0040,0xFFC0}, `out_ready`=1.
  - Beats idx0..3: err={0x0200,0xFF00,0x7FFF,0x0000}; grad={0x0100,0x0080,0x0040,0xFFC0}.
  - `out_last` only on idx3; `in_ready` high 5 cycles after accept.
- **Saturation:** `delta`=0x7FFF, `act[0]`=0x7FFF.
  - With macro: beat0 grad=0x7FFF, `out_sat`=1.
  - Without macro: beat0 grad=0xFF00, `out_sat`=0.
- **Back-pressure:** hold `out_ready`=0 for 3 cycles on beat1.
  - beat1 values stable, `out_valid` stays 1.
  - Sequence completes unchanged after release.
- **Input isolation:** toggle `delta`/`act` and hold `in_valid`=1 during RUN.
  - Outputs match captured values.
  - Second transaction is accepted only after beat3's handshake.
- **Reset mid-operation:** assert `rst_n`=0 asynchronously during beat2.
  - `out_valid`=0 immediately, all outputs 0.
  - After release `in_ready`=1 and a new transaction starts at idx0.
- **Negative rounding:** `delta`=0xFFFF (−1 LSB), `act[0]`=0x0001.
  - grad=0xFFFF (floor), `out_sat`=0.
